uart_tx_emitter: RTL and testbench

Transmit-only 8N1 UART serializer used as the SoC console output. It accepts one byte per valid/ready handshake and drives it onto the serial line LSB first. The bit period is derived from the clock frequency and baud rate parameters. The SoC reads the inverse of o_ready as the "busy sending" status bit (bit 9 of the UART control register).

---
 rtl/uart_tx_emitter.sv | 138 +++++++++++++
 tb/tb_uart_tx_emitter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_emitter.sv
// uart_tx_emitter: transmit-only 8N1 UART serializer for the SoC console.
// One byte is accepted per valid/ready handshake and shifted out LSB first
// as start(0), d0..d7, stop(1). Every bit is held for DIV clock cycles,
// where DIV = clk_freq_hz / baud_rate, clamped to a minimum of 1.
// Both outputs come straight from flops; nothing on the inputs reaches
// o_ready or o_uart_tx combinationally.
module uart_tx_emitter #(
    parameter int clk_freq_hz = 10000000,
    parameter int baud_rate   = 1000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_uart_tx
);

    // Bit period in clock cycles; a baud rate above the clock rate degrades
    // to one bit per cycle rather than a zero-length bit.
    localparam int DIV_RAW = clk_freq_hz / baud_rate;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    // Frame position of the stop bit; the frame ends once it has been held.
    localparam logic [3:0] LAST_BIT = 4'd9;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_r;
    logic [0:0]       state_s;
    logic [9:0]       shift_r;
    logic [9:0]       shift_s;
    logic [3:0]       bit_cnt_r;
    logic [3:0]       bit_cnt_s;
    logic [DIV_W-1:0] div_cnt_r;
    logic [DIV_W-1:0] div_cnt_s;
    logic             ready_r;
    logic             ready_s;
    logic             tx_r;
    logic             tx_s;

    logic             accept_s;
    logic             bit_done_s;

    // Handshake and end-of-bit qualifiers derived from registered state only.
    always_comb begin
        accept_s   = i_valid & ready_r;
        bit_done_s = (div_cnt_r == DIV_LAST);
    end

    // Next-state logic: frame load on accept, bit timing and shifting.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_cnt_s = bit_cnt_r;
        div_cnt_s = div_cnt_r;
        ready_s   = ready_r;
        tx_s      = tx_r;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    // Stop bit sits in the MSB so it falls out last.
                    shift_s   = {1'b1, i_data, 1'b0};
                    div_cnt_s = DIV_ZERO;
                    bit_cnt_s = 4'd0;
                    state_s   = ST_SHIFT;
                    ready_s   = 1'b0;
                    tx_s      = 1'b0;
                end else begin
                    ready_s   = 1'b1;
                    tx_s      = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (bit_done_s) begin
                    div_cnt_s = DIV_ZERO;
                    if (bit_cnt_r == LAST_BIT) begin
                        // Stop bit fully held: back to idle, ready on the
                        // same edge so back-to-back frames lose one cycle.
                        state_s   = ST_IDLE;
                        bit_cnt_s = 4'd0;
                        ready_s   = 1'b1;
                        tx_s      = 1'b1;
                    end else begin
                        shift_s   = {1'b0, shift_r[9:1]};
                        bit_cnt_s = bit_cnt_r + 4'd1;
                        ready_s   = 1'b0;
                        tx_s      = shift_r[1];
                    end
                end else begin
                    div_cnt_s = div_cnt_r + DIV_ONE;
                    ready_s   = 1'b0;
                    tx_s      = shift_r[0];
                end
            end

            default: begin
                state_s   = ST_IDLE;
                shift_s   = 10'd0;
                bit_cnt_s = 4'd0;
                div_cnt_s = DIV_ZERO;
                ready_s   = 1'b1;
                tx_s      = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            shift_r   <= 10'd0;
            bit_cnt_r <= 4'd0;
            div_cnt_r <= DIV_ZERO;
            ready_r   <= 1'b1;
            tx_r      <= 1'b1;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            bit_cnt_r <= bit_cnt_s;
            div_cnt_r <= div_cnt_s;
            ready_r   <= ready_s;
            tx_r      <= tx_s;
        end
    end

    assign o_ready   = ready_r;
    assign o_uart_tx = tx_r;

endmodule

// File: tb/tb_uart_tx_emitter.sv
// Directed self-checking bench for uart_tx_emitter: three instances cover
// DIV=10 (defaults), DIV=2 and the clamped DIV=1 case.
module tb_uart_tx_emitter;

    logic             clk = 1'b0;
    logic             resetn;
    logic [2:0]       valid;
    logic [2:0]       ready;
    logic [2:0]       tx;
    logic [2:0][7:0]  data;

    int               checks = 0;
    int               errors = 0;
    logic [7:0]       last_dec;
    logic [8*26-1:0]  got_text;

    localparam logic [8*26-1:0] ALPHA = "abcdefghijklmnopqrstuvwxyz";

    uart_tx_emitter u0 (
        .clk(clk), .resetn(resetn), .i_data(data[0]), .i_valid(valid[0]),
        .o_ready(ready[0]), .o_uart_tx(tx[0])
    );

    uart_tx_emitter #(.clk_freq_hz(12000000), .baud_rate(5000000)) u1 (
        .clk(clk), .resetn(resetn), .i_data(data[1]), .i_valid(valid[1]),
        .o_ready(ready[1]), .o_uart_tx(tx[1])
    );

    uart_tx_emitter #(.clk_freq_hz(1000), .baud_rate(2000)) u2 (
        .clk(clk), .resetn(resetn), .i_data(data[2]), .i_valid(valid[2]),
        .o_ready(ready[2]), .o_uart_tx(tx[2])
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Send one byte on instance idx and check every cycle of the frame.
    // Called and returns at a negedge with the instance idle.
    // mode 0: plain, 1: busy poke with 0x55, 2: scramble i_data every cycle.
    task automatic send_frame(input int idx, input int div, input logic [7:0] b,
                              input bit hold, input logic [7:0] next_b, input int mode);
        logic [9:0] frame;
        logic [7:0] dec;
        int         cyc;
        frame = {1'b1, b, 1'b0};
        check_eq($sformatf("u%0d_ready_idle", idx), 32'(ready[idx]), 32'd1);
        check_eq($sformatf("u%0d_tx_idle", idx), 32'(tx[idx]), 32'd1);
        valid[idx] = 1'b1;
        data[idx]  = b;
        @(negedge clk);
        if (hold) data[idx] = next_b;
        else valid[idx] = 1'b0;
        dec = 8'd0;
        cyc = 0;
        for (int bi = 0; bi < 10; bi++) begin
            for (int c = 0; c < div; c++) begin
                if (cyc != 0) @(negedge clk);
                if (mode == 2) data[idx] = 8'($urandom);
                if (mode == 1) begin
                    if (cyc == 30) begin
                        valid[idx] = 1'b1;
                        data[idx]  = 8'h55;
                    end else if (cyc == 31) begin
                        valid[idx] = 1'b0;
                    end
                end
                check_eq($sformatf("u%0d_%02h_bit%0d_c%0d", idx, b, bi, c),
                         32'(tx[idx]), 32'(frame[bi]));
                check_eq($sformatf("u%0d_%02h_busy_c%0d", idx, b, cyc),
                         32'(ready[idx]), 32'd0);
                if (c == div / 2 && bi >= 1 && bi <= 8) dec[bi-1] = tx[idx];
                cyc++;
            end
        end
        @(negedge clk);
        check_eq($sformatf("u%0d_%02h_ready_end", idx, b), 32'(ready[idx]), 32'd1);
        check_eq($sformatf("u%0d_%02h_tx_end", idx, b), 32'(tx[idx]), 32'd1);
        check_eq($sformatf("u%0d_%02h_decode", idx, b), 32'(dec), 32'(b));
        last_dec = dec;
    endtask

    // Check instance idx stays idle for n cycles.
    task automatic idle_check(input int idx, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq($sformatf("%s_tx_%0d", tag, i), 32'(tx[idx]), 32'd1);
            check_eq($sformatf("%s_ready_%0d", tag, i), 32'(ready[idx]), 32'd1);
        end
    endtask

    // Directed test sequence.
    initial begin
        resetn = 1'b1;
        valid  = 3'b000;
        data   = '0;
        #1 resetn = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst_ready_u%0d", i), 32'(ready[i]), 32'd1);
            check_eq($sformatf("rst_tx_u%0d", i), 32'(tx[i]), 32'd1);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Single byte 'a' at DIV=10.
        send_frame(0, 10, 8'h61, 1'b0, 8'h00, 0);

        // Busy rejection: 0x55 poked mid-frame must never go out.
        send_frame(0, 10, 8'h41, 1'b0, 8'h00, 1);
        idle_check(0, 30, "no55");

        // Back-to-back alphabet with i_valid held.
        got_text = '0;
        for (int i = 0; i < 26; i++) begin
            send_frame(0, 10, 8'(8'h61 + i), (i < 25), 8'(8'h62 + i), 0);
            got_text = {got_text[8*25-1:0], last_dec};
        end
        check_eq("alphabet_text", 32'(got_text == ALPHA), 32'd1);
        idle_check(0, 3, "post_alpha");

        // Data stability: i_data scrambled while 0x0D is in flight.
        send_frame(0, 10, 8'h0D, 1'b0, 8'h00, 2);
        send_frame(0, 10, 8'h0A, 1'b0, 8'h00, 0);

        // Parameter corners: DIV=2 and clamped DIV=1.
        send_frame(1, 2, 8'hA5, 1'b0, 8'h00, 0);
        send_frame(1, 2, 8'h3C, 1'b0, 8'h00, 0);
        send_frame(2, 1, 8'h5A, 1'b0, 8'h00, 0);
        send_frame(2, 1, 8'h01, 1'b1, 8'h80, 0);
        send_frame(2, 1, 8'h80, 1'b0, 8'h00, 0);
        idle_check(2, 3, "u2_idle");

        // Asynchronous reset 35 cycles into an 'a' frame (inside d2 = 0).
        valid[0] = 1'b1;
        data[0]  = 8'h61;
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (34) @(negedge clk);
        check_eq("pre_rst_ready", 32'(ready[0]), 32'd0);
        check_eq("pre_rst_tx", 32'(tx[0]), 32'd0);
        #2 resetn = 1'b0;
        #1;
        check_eq("async_rst_ready", 32'(ready[0]), 32'd1);
        check_eq("async_rst_tx", 32'(tx[0]), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        idle_check(0, 20, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
